// File: rtl/perturbation_irq_ctrl_if.sv
// Bundles the configuration bus, the ID-stage PC feed and the interrupt
// request/acknowledge handshake of the perturbation interrupt controller.
//   cfg_we_i/cfg_re_i/cfg_addr_i/cfg_wdata_i : register write/read requests
//   cfg_rdata_o                              : read data, one cycle after cfg_re_i
//   pc_valid_i/pc_id_i                       : ID-stage PC and its valid flag
//   irq_ack_i/irq_ack_id_i                   : core acknowledge and accepted id
//   irq_o/irq_id_o                           : interrupt request level and id
//   busy_o                                   : controller not idle
// master = testbench / config side, slave = controller.
interface perturbation_irq_ctrl_if #(
    parameter int ID_W = 5
);
    logic            cfg_we_i;
    logic            cfg_re_i;
    logic [2:0]      cfg_addr_i;
    logic [31:0]     cfg_wdata_i;
    logic [31:0]     cfg_rdata_o;
    logic            pc_valid_i;
    logic [31:0]     pc_id_i;
    logic            irq_ack_i;
    logic [ID_W-1:0] irq_ack_id_i;
    logic            irq_o;
    logic [ID_W-1:0] irq_id_o;
    logic            busy_o;

    modport master (
        output cfg_we_i, cfg_re_i, cfg_addr_i, cfg_wdata_i,
        output pc_valid_i, pc_id_i, irq_ack_i, irq_ack_id_i,
        input  cfg_rdata_o, irq_o, irq_id_o, busy_o
    );

    modport slave (
        input  cfg_we_i, cfg_re_i, cfg_addr_i, cfg_wdata_i,
        input  pc_valid_i, pc_id_i, irq_ack_i, irq_ack_id_i,
        output cfg_rdata_o, irq_o, irq_id_o, busy_o
    );
endinterface

// File: rtl/perturbation_irq_ctrl.sv
// Interrupt perturbation sequencer for the core testbench. Modes: STANDARD
// (periodic, fixed id), RANDOM (LFSR-chosen delay and id) and PC_TRIG (one-shot
// id 0x12 on an ID-stage PC match). One request outstanding at a time, held
// until acknowledged with the matching id.
//   clk_i  : clock
//   rst_ni : synchronous active-low reset
//   bus    : config bus, PC feed and irq handshake (slave side)
module perturbation_irq_ctrl #(
    parameter int          DLY_W     = 8,
    parameter logic [31:0] LFSR_POLY = 32'h8020_0003,
    parameter int          ID_W      = 5
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    perturbation_irq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_REQ} state_e;
    typedef enum logic [1:0] {M_OFF = 2'd0, M_STD = 2'd1, M_RND = 2'd2, M_PC = 2'd3} mode_e;

    localparam logic [DLY_W:0]  CNT_ONE = (DLY_W+1)'(1);
    localparam logic [ID_W-1:0] PC_ID   = ID_W'(5'h12);

    state_e          state_q, state_d;
    mode_e           mode_q, mode_d;
    logic [31:0]     lfsr_q, lfsr_d;
    logic [31:0]     pc_target_q, pc_target_d;
    logic [ID_W-1:0] std_id_q, std_id_d;
    logic [DLY_W-1:0] std_period_q, std_period_d;
    logic [31:0]     fire_cnt_q, fire_cnt_d;
    logic [DLY_W:0]  cnt_q, cnt_d;
    logic [ID_W-1:0] pend_id_q, pend_id_d;
    logic            irq_q, irq_d;
    logic [ID_W-1:0] irq_id_q, irq_id_d;
    logic [31:0]     rdata_q, rdata_d;

    logic            wr_mode, wr_seed, wr_pc, wr_std, ack_ok;
    mode_e           new_mode, load_mode;
    logic [DLY_W:0]  load_cnt;
    logic [ID_W-1:0] load_id;

    always_comb begin
        wr_mode = bus.cfg_we_i && (bus.cfg_addr_i == 3'd0);
        wr_seed = bus.cfg_we_i && (bus.cfg_addr_i == 3'd1);
        wr_pc   = bus.cfg_we_i && (bus.cfg_addr_i == 3'd2);
        wr_std  = bus.cfg_we_i && (bus.cfg_addr_i == 3'd3);
        ack_ok  = (state_q == S_REQ) && bus.irq_ack_i && (bus.irq_ack_id_i == irq_id_q);

        new_mode = M_OFF;
        if (bus.cfg_wdata_i == 32'd1)      new_mode = M_STD;
        else if (bus.cfg_wdata_i == 32'd2) new_mode = M_RND;
        else if (bus.cfg_wdata_i == 32'd3) new_mode = M_PC;

        // Counter/id load uses the mode being entered: the new one on a MODE
        // write, otherwise the current one (reload after ack).
        load_mode = wr_mode ? new_mode : mode_q;
        load_cnt  = CNT_ONE;
        load_id   = PC_ID;
        case (load_mode)
            M_STD: begin
                load_cnt = (std_period_q == '0) ? CNT_ONE : {1'b0, std_period_q};
                load_id  = std_id_q;
            end
            M_RND: begin
                load_cnt = {1'b0, lfsr_q[DLY_W-1:0]} + CNT_ONE;
                load_id  = lfsr_q[31 -: ID_W];
            end
            default: ;
        endcase

        mode_d       = mode_q;
        lfsr_d       = lfsr_q;
        pc_target_d  = pc_target_q;
        std_id_d     = std_id_q;
        std_period_d = std_period_q;
        fire_cnt_d   = fire_cnt_q;
        state_d      = state_q;
        cnt_d        = cnt_q;
        pend_id_d    = pend_id_q;
        irq_d        = irq_q;
        irq_id_d     = irq_id_q;
        rdata_d      = rdata_q;

        if (wr_seed)               lfsr_d = (bus.cfg_wdata_i == '0) ? 32'd1 : bus.cfg_wdata_i;
        else if (mode_q == M_RND)  lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_POLY) : (lfsr_q >> 1);
        if (wr_pc) pc_target_d = bus.cfg_wdata_i;
        if (wr_std) begin
            std_id_d     = bus.cfg_wdata_i[ID_W-1:0];
            std_period_d = bus.cfg_wdata_i[8 +: DLY_W];
        end

        if (wr_mode) begin
            // A MODE write aborts everything, including a same-cycle ack.
            mode_d  = new_mode;
            irq_d   = 1'b0;
            state_d = (new_mode == M_OFF) ? S_IDLE : S_WAIT;
            cnt_d   = load_cnt;
            pend_id_d = load_id;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (wr_pc && (mode_q == M_PC)) begin
                        state_d   = S_WAIT;
                        pend_id_d = PC_ID;
                    end
                end
                S_WAIT: begin
                    if (mode_q == M_PC) begin
                        if (bus.pc_valid_i && (bus.pc_id_i == pc_target_q)) begin
                            state_d  = S_REQ;
                            irq_d    = 1'b1;
                            irq_id_d = pend_id_q;
                        end
                    end else if (cnt_q == CNT_ONE) begin
                        state_d  = S_REQ;
                        irq_d    = 1'b1;
                        irq_id_d = pend_id_q;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                S_REQ: begin
                    if (ack_ok) begin
                        irq_d      = 1'b0;
                        fire_cnt_d = fire_cnt_q + 32'd1;
                        state_d    = (mode_q == M_PC) ? S_IDLE : S_WAIT;
                        cnt_d      = load_cnt;
                        pend_id_d  = load_id;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (bus.cfg_re_i) begin
            rdata_d = '0;
            case (bus.cfg_addr_i)
                3'd0: rdata_d[1:0] = mode_q;
                3'd1: rdata_d = lfsr_q;
                3'd2: rdata_d = pc_target_q;
                3'd3: begin
                    rdata_d[ID_W-1:0]   = std_id_q;
                    rdata_d[8 +: DLY_W] = std_period_q;
                end
                3'd4: rdata_d = fire_cnt_q;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            mode_q       <= M_OFF;
            lfsr_q       <= 32'd1;
            pc_target_q  <= '0;
            std_id_q     <= '0;
            std_period_q <= DLY_W'(1);
            fire_cnt_q   <= '0;
            cnt_q        <= '0;
            pend_id_q    <= '0;
            irq_q        <= 1'b0;
            irq_id_q     <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            lfsr_q       <= lfsr_d;
            pc_target_q  <= pc_target_d;
            std_id_q     <= std_id_d;
            std_period_q <= std_period_d;
            fire_cnt_q   <= fire_cnt_d;
            cnt_q        <= cnt_d;
            pend_id_q    <= pend_id_d;
            irq_q        <= irq_d;
            irq_id_q     <= irq_id_d;
            rdata_q      <= rdata_d;
        end
    end

    assign bus.irq_o       = irq_q;
    assign bus.irq_id_o    = irq_id_q;
    assign bus.cfg_rdata_o = rdata_q;
    assign bus.busy_o      = (state_q != S_IDLE);
endmodule

// File: tb/tb_perturbation_irq_ctrl.sv
// Directed self-checking bench for perturbation_irq_ctrl.
module tb_perturbation_irq_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   nvec = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    perturbation_irq_ctrl_if #(.ID_W(5)) bus ();

    perturbation_irq_ctrl #(
        .DLY_W     (8),
        .LFSR_POLY (32'h8020_0003),
        .ID_W      (5)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_wr(input logic [2:0] addr, input logic [31:0] data);
        bus.cfg_we_i    = 1'b1;
        bus.cfg_addr_i  = addr;
        bus.cfg_wdata_i = data;
        tick();
        bus.cfg_we_i    = 1'b0;
    endtask

    task automatic cfg_rd(input logic [2:0] addr, output logic [31:0] data);
        bus.cfg_re_i   = 1'b1;
        bus.cfg_addr_i = addr;
        tick();
        bus.cfg_re_i   = 1'b0;
        data = bus.cfg_rdata_o;
    endtask

    // Ticks until irq_o is seen high or max cycles elapse; n = ticks taken.
    task automatic wait_irq(input int max, output int n);
        n = 0;
        while (!bus.irq_o && n < max) begin
            tick();
            n++;
        end
    endtask

    task automatic ack(input logic [4:0] id);
        bus.irq_ack_i    = 1'b1;
        bus.irq_ack_id_i = id;
        tick();
        bus.irq_ack_i    = 1'b0;
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
    endfunction

    // Seeds the LFSR, starts RANDOM mode and checks the delay/id of nfires
    // requests against the reference LFSR started from eff.
    task automatic run_rnd(input string tag, input logic [31:0] seed, input logic [31:0] eff,
                           input int nfires);
        logic [31:0] m;
        int          d, n, steps;
        cfg_wr(3'd0, 32'd0);
        cfg_wr(3'd1, seed);
        cfg_wr(3'd0, 32'd2);
        m = eff;
        for (int k = 0; k < nfires; k++) begin
            d = int'(m[7:0]) + 1;
            wait_irq(300, n);
            check($sformatf("%s_dly%0d", tag, k), n, d);
            check($sformatf("%s_id%0d", tag, k), {27'd0, bus.irq_id_o}, {27'd0, m[31:27]});
            ack(m[31:27]);
            check($sformatf("%s_low%0d", tag, k), {31'd0, bus.irq_o}, 32'd0);
            // First load happens before the LFSR starts stepping.
            steps = (k == 0) ? d : d + 1;
            for (int s = 0; s < steps; s++) m = lfsr_step(m);
        end
        cfg_wr(3'd0, 32'd0);
    endtask

    logic [31:0] rd;
    int          n;

    initial begin
        rst_n            = 1'b0;
        bus.cfg_we_i     = 1'b0;
        bus.cfg_re_i     = 1'b0;
        bus.cfg_addr_i   = '0;
        bus.cfg_wdata_i  = '0;
        bus.pc_valid_i   = 1'b0;
        bus.pc_id_i      = '0;
        bus.irq_ack_i    = 1'b0;
        bus.irq_ack_id_i = '0;
        tick();
        tick();
        check("rst_irq",   {31'd0, bus.irq_o}, 32'd0);
        check("rst_id",    {27'd0, bus.irq_id_o}, 32'd0);
        check("rst_busy",  {31'd0, bus.busy_o}, 32'd0);
        check("rst_rdata", bus.cfg_rdata_o, 32'd0);
        rst_n = 1'b1;
        tick();
        cfg_rd(3'd0, rd); check("rst_mode", rd, 32'd0);
        cfg_rd(3'd1, rd); check("rst_seed", rd, 32'd1);
        cfg_rd(3'd3, rd); check("rst_std",  rd, 32'h0000_0100);
        cfg_rd(3'd4, rd); check("rst_fire", rd, 32'd0);
        cfg_wr(3'd4, 32'h55);
        cfg_wr(3'd6, 32'h77);
        cfg_rd(3'd4, rd); check("fire_ro", rd, 32'd0);
        cfg_rd(3'd6, rd); check("rd6_zero", rd, 32'd0);

        // STANDARD, period 4 id 7: MODE at t -> high at t+5; ack at t+7.
        cfg_wr(3'd3, 32'h0000_0407);
        cfg_wr(3'd0, 32'd1);
        check("std_busy", {31'd0, bus.busy_o}, 32'd1);
        wait_irq(50, n);
        check("std_dly1", n, 4);
        check("std_id", {27'd0, bus.irq_id_o}, 32'd7);
        tick();
        ack(5'd7);
        check("std_ack_low", {31'd0, bus.irq_o}, 32'd0);
        wait_irq(50, n);
        check("std_dly2", n, 4);

        // Wrong-id ack is ignored; matching ack counts.
        ack(5'd3);
        check("badack_irq", {31'd0, bus.irq_o}, 32'd1);
        cfg_rd(3'd4, rd); check("badack_fire", rd, 32'd1);
        ack(5'd7);
        cfg_rd(3'd4, rd); check("ack_fire", rd, 32'd2);

        // MODE=0 together with a matching ack: abort wins, no count.
        wait_irq(50, n);
        check("abort_pre", {31'd0, bus.irq_o}, 32'd1);
        bus.irq_ack_i    = 1'b1;
        bus.irq_ack_id_i = 5'd7;
        cfg_wr(3'd0, 32'd0);
        bus.irq_ack_i    = 1'b0;
        check("abort_irq",  {31'd0, bus.irq_o}, 32'd0);
        check("abort_busy", {31'd0, bus.busy_o}, 32'd0);
        cfg_rd(3'd4, rd); check("abort_fire", rd, 32'd2);
        wait_irq(10, n);
        check("abort_quiet", {31'd0, bus.irq_o}, 32'd0);

        // Period 0 behaves as period 1.
        cfg_wr(3'd3, 32'h0000_0009);
        cfg_wr(3'd0, 32'd1);
        wait_irq(10, n);
        check("p0_dly", n, 1);
        check("p0_id", {27'd0, bus.irq_id_o}, 32'd9);
        cfg_wr(3'd0, 32'd0);

        // PC_TRIG one-shot with rearm.
        cfg_wr(3'd2, 32'h0000_01C0);
        cfg_wr(3'd0, 32'd3);
        bus.pc_valid_i = 1'b1; bus.pc_id_i = 32'h1BC;
        tick();
        check("pc_nomatch", {31'd0, bus.irq_o}, 32'd0);
        bus.pc_valid_i = 1'b0; bus.pc_id_i = 32'h1C0;
        tick();
        check("pc_invalid", {31'd0, bus.irq_o}, 32'd0);
        bus.pc_valid_i = 1'b1;
        tick();
        bus.pc_valid_i = 1'b0;
        check("pc_irq", {31'd0, bus.irq_o}, 32'd1);
        check("pc_id",  {27'd0, bus.irq_id_o}, 32'h12);
        ack(5'h12);
        check("pc_ack_low",  {31'd0, bus.irq_o}, 32'd0);
        check("pc_ack_idle", {31'd0, bus.busy_o}, 32'd0);
        bus.pc_valid_i = 1'b1;
        tick();
        tick();
        check("pc_oneshot", {31'd0, bus.irq_o}, 32'd0);
        bus.pc_valid_i = 1'b0;
        cfg_wr(3'd2, 32'h0000_01C0);
        check("pc_rearm_busy", {31'd0, bus.busy_o}, 32'd1);
        // Match in the same cycle as a target rewrite uses the old target.
        bus.pc_valid_i = 1'b1;
        cfg_wr(3'd2, 32'h0000_0200);
        bus.pc_valid_i = 1'b0;
        check("pc_old_tgt", {31'd0, bus.irq_o}, 32'd1);
        ack(5'h12);
        cfg_rd(3'd4, rd); check("pc_fire", rd, 32'd4);
        cfg_wr(3'd0, 32'd0);

        // RANDOM: model-checked sequences, reseed repeat, seed 0 == seed 1.
        run_rnd("rndA", 32'h0000_ACE1, 32'h0000_ACE1, 3);
        run_rnd("rndB", 32'h0000_ACE1, 32'h0000_ACE1, 3);
        run_rnd("rnd0", 32'h0000_0000, 32'h0000_0001, 3);
        run_rnd("rnd1", 32'h0000_0001, 32'h0000_0001, 3);
        run_rnd("rndF", 32'hF800_0010, 32'hF800_0010, 2);

        // Reset mid-WAIT clears everything.
        cfg_wr(3'd3, 32'h0000_1405);
        cfg_wr(3'd0, 32'd1);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mrst_irq",  {31'd0, bus.irq_o}, 32'd0);
        check("mrst_id",   {27'd0, bus.irq_id_o}, 32'd0);
        check("mrst_busy", {31'd0, bus.busy_o}, 32'd0);
        check("mrst_rdata", bus.cfg_rdata_o, 32'd0);
        cfg_rd(3'd0, rd); check("mrst_mode", rd, 32'd0);
        cfg_rd(3'd4, rd); check("mrst_fire", rd, 32'd0);
        wait_irq(40, n);
        check("mrst_quiet", {31'd0, bus.irq_o}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
